spi_slave: RTL and testbench
============================

SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 Parameters: none; byte width fixed at 8, LSB-first, one bit per rising sclk_o edge.
REQ-002 sclk_o  input  1  clock; all state updates on rising edge.
REQ-003 nrst_i  input  1  reset, asynchronous, active-low.
REQ-004 cs_i  input  1  chip select, active-low; frame active while low.
REQ-005 mosi_i  input  1  serial data from master.
REQ-006 miso_o  output  1  serial data to master.
REQ-007 tx_data_i  input  8  byte to transmit in next frame.
REQ-008 tx_valid_i  input  1  tx_data_i valid.
REQ-009 tx_ready_o  output  1  tx holding buffer empty; accepts a write.
REQ-010 rx_data_o  output  8  last complete received byte.
REQ-011 rx_valid_o  output  1  rx_data_o holds an unconsumed byte.
REQ-012 rx_ready_i  input  1  consumer accepts rx_data_o.
REQ-013 overrun_o  output  1  sticky: received byte overwrote unconsumed byte.
REQ-014 underrun_o  output  1  sticky: frame started with empty tx buffer.
REQ-015 frame_err_o  output  1  sticky: cs_i deasserted mid-byte.

Function
REQ-016 States IDLE, LOAD, SHIFT; 3-bit bit counter cnt; 8-bit shift register sr; 8-bit tx buffer txb with full flag.
REQ-017 IDLE: cs_i high -> stay; cs_i low -> LOAD evaluated same edge (load performed on that edge, next state SHIFT, cnt<=0).
REQ-018 LOAD action: txb full -> sr<=txb, txb emptied; txb empty -> sr<=8'h00, underrun_o<=1.
REQ-019 SHIFT, cs_i low: sr<={mosi_i, sr[7:1]}, cnt<=cnt+1.
REQ-020 SHIFT edge with cnt==7 and cs_i low: rx_data_o<={mosi_i, sr[7:1]}, rx_valid_o<=1; next edge performs LOAD if cs_i low (back-to-back byte, no gap), else IDLE.
REQ-021 miso_o = sr[0] when state SHIFT and cs_i low, else 0 (combinational from registers/cs_i); master sees bit0 first.
REQ-022 SHIFT with cs_i high: -> IDLE, partial byte discarded, rx_* unchanged; frame_err_o<=1 if cnt!=0.
REQ-023 Tx write: tx_valid_i && tx_ready_o on an edge -> txb<=tx_data_i, full<=1; tx_ready_o = !full.
REQ-024 Write and LOAD on same edge with txb empty: load uses 8'h00 (underrun set), written byte kept in txb for next frame.
REQ-025 Write and LOAD on same edge with txb full: tx_ready_o low, write not accepted; load consumes old txb.
REQ-026 Rx consume: rx_valid_o && rx_ready_i on an edge -> rx_valid_o<=0, unless a byte completes on same edge (then rx_valid_o stays 1, new data, no overrun).
REQ-027 Byte completes while rx_valid_o=1 and rx_ready_i=0: rx_data_o overwritten, overrun_o<=1.
REQ-028 Sticky flags clear only on reset.
REQ-029 Latency: byte on rx_data_o on the 8th SHIFT edge of the frame; tx byte must be in txb before the LOAD edge.

Reset
REQ-030 nrst_i low asynchronously forces state IDLE, cnt=0, sr=0, txb empty, rx_data_o=0, rx_valid_o=0, overrun_o=0, underrun_o=0, frame_err_o=0; hence miso_o=0, tx_ready_o=1.
REQ-031 Reset mid-frame aborts without flag set; first edge after release with cs_i low is a LOAD.

Verification
REQ-032 Write 0xA5, cs_i low 9 edges, mosi 0x3C LSB-first -> miso bits 1,0,1,0,0,1,0,1; rx_data_o=0x3C, rx_valid_o=1 on 9th edge; underrun_o=0.
REQ-033 No tx write, one frame -> miso all 0, underrun_o=1, tx_ready_o=1 throughout.
REQ-034 Two back-to-back frames mosi 0x11 then 0x22, rx_ready_i=0 -> rx_data_o=0x22, overrun_o=1; repeat with rx_ready_i=1 -> overrun_o=0.
REQ-035 cs_i high after 3 shift edges -> IDLE, frame_err_o=1, rx_valid_o unchanged; next full frame received correctly.
REQ-036 nrst_i low after 5 shift edges -> all outputs at reset values immediately; subsequent frame 0x5A received as 0x5A.
REQ-037 tx write coincident with LOAD edge, txb empty -> frame sends 0x00, underrun_o=1, next frame sends written byte.

Source files
------------

// File: rtl/spi_slave.sv
// SPI slave, mode-0 style sampling on rising sclk_o, LSB-first, 8-bit bytes.
// Single-entry tx holding buffer and rx output register with sticky error flags.
module spi_slave (
  input  logic       sclk_o,
  input  logic       nrst_i,
  input  logic       cs_i,
  input  logic       mosi_i,
  output logic       miso_o,
  input  logic [7:0] tx_data_i,
  input  logic       tx_valid_i,
  output logic       tx_ready_o,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  input  logic       rx_ready_i,
  output logic       overrun_o,
  output logic       underrun_o,
  output logic       frame_err_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2
  } state_t;

  state_t     state_r, state_s;
  logic [2:0] cnt_r;
  logic [7:0] sr_r;
  logic [7:0] txb_r;
  logic       full_r;
  logic       do_load_s, do_shift_s, byte_done_s, abort_err_s;

  // Next-state and per-edge action strobes; IDLE and LOAD both load on a low cs_i.
  always_comb begin
    state_s     = state_r;
    do_load_s   = 1'b0;
    do_shift_s  = 1'b0;
    byte_done_s = 1'b0;
    abort_err_s = 1'b0;
    case (state_r)
      IDLE, LOAD: begin
        if (!cs_i) begin
          do_load_s = 1'b1;
          state_s   = SHIFT;
        end else begin
          state_s = IDLE;
        end
      end
      SHIFT: begin
        if (!cs_i) begin
          do_shift_s = 1'b1;
          if (cnt_r == 3'd7) begin
            byte_done_s = 1'b1;
            state_s     = LOAD;
          end else begin
            state_s = SHIFT;
          end
        end else begin
          state_s     = IDLE;
          abort_err_s = (cnt_r != 3'd0);
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge sclk_o or negedge nrst_i) begin
    if (!nrst_i) state_r <= IDLE;
    else         state_r <= state_s;
  end

  // Shift register and bit counter; an empty buffer at load time sends zeros.
  always_ff @(posedge sclk_o or negedge nrst_i) begin
    if (!nrst_i) begin
      sr_r  <= 8'h00;
      cnt_r <= 3'd0;
    end else if (do_load_s) begin
      sr_r  <= full_r ? txb_r : 8'h00;
      cnt_r <= 3'd0;
    end else if (do_shift_s) begin
      sr_r  <= {mosi_i, sr_r[7:1]};
      cnt_r <= cnt_r + 3'd1;
    end
  end

  // Tx holding buffer; a load of a full buffer wins over a same-edge write.
  always_ff @(posedge sclk_o or negedge nrst_i) begin
    if (!nrst_i) begin
      txb_r       <= 8'h00;
      full_r      <= 1'b0;
      underrun_o  <= 1'b0;
      frame_err_o <= 1'b0;
    end else begin
      if (do_load_s && full_r) begin
        full_r <= 1'b0;
      end else if (tx_valid_i && !full_r) begin
        txb_r  <= tx_data_i;
        full_r <= 1'b1;
      end
      if (do_load_s && !full_r) underrun_o  <= 1'b1;
      if (abort_err_s)          frame_err_o <= 1'b1;
    end
  end

  // Rx output register; a completing byte takes priority over consumption.
  always_ff @(posedge sclk_o or negedge nrst_i) begin
    if (!nrst_i) begin
      rx_data_o  <= 8'h00;
      rx_valid_o <= 1'b0;
      overrun_o  <= 1'b0;
    end else if (byte_done_s) begin
      rx_data_o  <= {mosi_i, sr_r[7:1]};
      rx_valid_o <= 1'b1;
      if (rx_valid_o && !rx_ready_i) overrun_o <= 1'b1;
    end else if (rx_valid_o && rx_ready_i) begin
      rx_valid_o <= 1'b0;
    end
  end

  assign miso_o     = (state_r == SHIFT && !cs_i) ? sr_r[0] : 1'b0;
  assign tx_ready_o = !full_r;

endmodule

// File: tb/tb_spi_slave.sv
// Self-checking bench for spi_slave: directed scenarios plus randomized traffic
// compared against a byte-slot level reference model.
module tb_spi_slave;

  logic       sclk_o = 1'b0;
  logic       nrst_i = 1'b0;
  logic       cs_i = 1'b1;
  logic       mosi_i = 1'b0;
  logic       miso_o;
  logic [7:0] tx_data_i = 8'h00;
  logic       tx_valid_i = 1'b0;
  logic       tx_ready_o;
  logic [7:0] rx_data_o;
  logic       rx_valid_o;
  logic       rx_ready_i = 1'b0;
  logic       overrun_o, underrun_o, frame_err_o;

  spi_slave dut (
    .sclk_o(sclk_o), .nrst_i(nrst_i), .cs_i(cs_i), .mosi_i(mosi_i), .miso_o(miso_o),
    .tx_data_i(tx_data_i), .tx_valid_i(tx_valid_i), .tx_ready_o(tx_ready_o),
    .rx_data_o(rx_data_o), .rx_valid_o(rx_valid_o), .rx_ready_i(rx_ready_i),
    .overrun_o(overrun_o), .underrun_o(underrun_o), .frame_err_o(frame_err_o)
  );

  always #5 sclk_o = ~sclk_o;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: a frame is a sequence of 9-edge byte slots
  // (slot position 0 = load edge, positions 1..8 = data bits 0..7).
  bit       m_in_frame;
  int       m_pos;
  bit [7:0] m_tx_byte, m_rx_acc, m_txb, m_rx_data;
  bit       m_full, m_rx_valid, m_ovr, m_und, m_ferr;
  bit [7:0] miso_log;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    m_in_frame = 1'b0; m_pos = 0; m_tx_byte = 8'h00; m_rx_acc = 8'h00;
    m_txb = 8'h00; m_full = 1'b0; m_rx_data = 8'h00; m_rx_valid = 1'b0;
    m_ovr = 1'b0; m_und = 1'b0; m_ferr = 1'b0;
  endfunction

  function automatic void model_edge(bit cs, bit mosi, bit txv, bit [7:0] txd, bit rdy);
    bit full_old = m_full;
    bit load = 1'b0;
    bit done = 1'b0;
    if (!cs) begin
      if (m_pos == 0) begin
        load = 1'b1; m_in_frame = 1'b1; m_pos = 1;
        m_tx_byte = full_old ? m_txb : 8'h00;
        if (!full_old) m_und = 1'b1;
      end else begin
        m_rx_acc[m_pos-1] = mosi;
        if (m_pos == 8) begin done = 1'b1; m_pos = 0; end
        else m_pos++;
      end
    end else begin
      if (m_in_frame && m_pos >= 2) m_ferr = 1'b1;
      m_in_frame = 1'b0; m_pos = 0;
    end
    if (load && full_old) m_full = 1'b0;
    else if (txv && !full_old) begin m_txb = txd; m_full = 1'b1; end
    if (done) begin
      if (m_rx_valid && !rdy) m_ovr = 1'b1;
      m_rx_data = m_rx_acc; m_rx_valid = 1'b1;
    end else if (m_rx_valid && rdy) m_rx_valid = 1'b0;
  endfunction

  task automatic check_outputs(input string ph);
    check_val({ph, "_rx_data"},  rx_data_o,   m_rx_data);
    check_val({ph, "_rx_valid"}, rx_valid_o,  m_rx_valid);
    check_val({ph, "_overrun"},  overrun_o,   m_ovr);
    check_val({ph, "_underrun"}, underrun_o,  m_und);
    check_val({ph, "_frame_err"}, frame_err_o, m_ferr);
    check_val({ph, "_tx_ready"}, tx_ready_o,  !m_full);
  endtask

  // One clock edge: drive on negedge, check miso before the edge, check state after.
  task automatic step(input bit cs, input bit mosi, input bit txv, input bit [7:0] txd, input bit rdy);
    bit exp_miso;
    @(negedge sclk_o);
    cs_i = cs; mosi_i = mosi; tx_valid_i = txv; tx_data_i = txd; rx_ready_i = rdy;
    #1;
    exp_miso = (m_in_frame && m_pos >= 1 && !cs) ? m_tx_byte[m_pos-1] : 1'b0;
    check_val("miso", miso_o, exp_miso);
    if (m_in_frame && m_pos >= 1 && !cs) miso_log[m_pos-1] = miso_o;
    check_val("pre_tx_ready", tx_ready_o, !m_full);
    @(posedge sclk_o);
    model_edge(cs, mosi, txv, txd, rdy);
    #1;
    check_outputs("post");
  endtask

  task automatic async_reset();
    #2;
    nrst_i = 1'b0;
    #1;
    model_reset();
    check_val("rst_miso", miso_o, 1'b0);
    check_outputs("rst");
    nrst_i = 1'b1;
  endtask

  // Load edge (optionally with a tx write) followed by 8 data edges.
  task automatic send_byte(input bit [7:0] mbyte, input bit txv, input bit [7:0] txd, input bit rdy);
    step(1'b0, 1'b0, txv, txd, rdy);
    for (int i = 0; i < 8; i++) step(1'b0, mbyte[i], 1'b0, 8'h00, rdy);
  endtask

  task automatic write_tx(input bit [7:0] d);
    step(1'b1, 1'b0, 1'b1, d, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    #3;
    check_outputs("reset");
    check_val("reset_miso", miso_o, 1'b0);
    nrst_i = 1'b1;
    step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);

    // Basic transfer: send 0xA5, receive 0x3C.
    write_tx(8'hA5);
    send_byte(8'h3C, 1'b0, 8'h00, 1'b0);
    check_val("basic_miso_bits", miso_log, 8'hA5);
    check_val("basic_rx", rx_data_o, 8'h3C);
    check_val("basic_valid", rx_valid_o, 1'b1);
    check_val("basic_und", underrun_o, 1'b0);
    step(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);

    // Underrun: frame with nothing written.
    async_reset();
    send_byte(8'hC3, 1'b0, 8'h00, 1'b1);
    check_val("und_miso_bits", miso_log, 8'h00);
    check_val("und_flag", underrun_o, 1'b1);
    step(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);

    // Back-to-back bytes, consumer stalled, then consuming.
    async_reset();
    send_byte(8'h11, 1'b0, 8'h00, 1'b0);
    send_byte(8'h22, 1'b0, 8'h00, 1'b0);
    check_val("b2b_rx", rx_data_o, 8'h22);
    check_val("b2b_ovr", overrun_o, 1'b1);
    step(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
    async_reset();
    send_byte(8'h11, 1'b0, 8'h00, 1'b1);
    send_byte(8'h22, 1'b0, 8'h00, 1'b1);
    check_val("b2b_rdy_ovr", overrun_o, 1'b0);
    check_val("b2b_rdy_rx", rx_data_o, 8'h22);
    step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);

    // Aborted frame after 3 data edges, then a clean frame.
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    check_val("abort_ferr", frame_err_o, 1'b1);
    check_val("abort_rx_keep", rx_data_o, 8'h22);
    send_byte(8'h96, 1'b0, 8'h00, 1'b1);
    check_val("after_abort_rx", rx_data_o, 8'h96);
    step(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);

    // Reset in the middle of a frame, then 0x5A.
    write_tx(8'h77);
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    async_reset();
    send_byte(8'h5A, 1'b0, 8'h00, 1'b0);
    check_val("post_rst_rx", rx_data_o, 8'h5A);
    check_val("post_rst_ferr", frame_err_o, 1'b0);
    step(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);

    // Write coincident with the load edge on an empty buffer.
    async_reset();
    send_byte(8'h01, 1'b1, 8'hE7, 1'b1);
    check_val("coinc_miso_bits", miso_log, 8'h00);
    check_val("coinc_und", underrun_o, 1'b1);
    check_val("coinc_kept", tx_ready_o, 1'b0);
    send_byte(8'h02, 1'b0, 8'h00, 1'b1);
    check_val("coinc_next_bits", miso_log, 8'hE7);
    step(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 499) == 0) async_reset();
      step(($urandom_range(0, 11) == 0), 1'($urandom), 1'($urandom), 8'($urandom), 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
